noc_injector: RTL
=================

Name: noc_injector

Overview:
- Source-side network interface: accepts packets from a local core and serialises them into HEADER/BODY/TAIL flits on one router input port.
- Drives flit and enable, and consumes ack, using the same node_port handshake the router nodes use on their input side.
- Buffers each whole packet before launch so enable never gaps between HEADER and TAIL.
- Instantiated once per mesh node, attached to that node's local (injection) port.

Parameters:
- X, 1, row coordinate of this node; used as header src_addr.x.
- Y, 1, column coordinate of this node; used as header src_addr.y.
- X_EDGE, 1, maximum legal row index (inclusive).
- Y_EDGE, 1, maximum legal column index (inclusive).
- DEPTH, 8, payload FIFO entries (power of 2); maximum packet length in words.
- DESC_DEPTH, 2, descriptor FIFO entries (power of 2).

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-low.
- msg_valid  input  1  descriptor valid.
- msg_ready  output  1  descriptor FIFO not full.
- msg_dst  input  addr_t  packet destination.
- wr_valid  input  1  payload word valid.
- wr_ready  output  1  payload FIFO not full.
- wr_data  input  $bits(flit_t.payload)  payload word.
- wr_last  input  1  last word of the packet.
- net  node_port.up  -  drives net.flit and net.enable; samples net.ack.
- busy  output  1  state != IDLE.
- err_dst  output  1  one-cycle pulse when a packet is dropped for an illegal destination.
- pkt_cnt  output  16  packets fully sent; wraps 0xFFFF -> 0.

Behaviour:
- Reset: sampled on the clk edge when rst==0. Clears state to IDLE, both FIFOs, the complete-packet counter and pkt_cnt.
  - Outputs after reset: net.enable=0, net.flit=0, busy=0, err_dst=0, msg_ready=1, wr_ready=1.
  - Reset mid-packet aborts immediately: enable drops, and the partial packet and all queued data are discarded.
- Descriptor push: on msg_valid && msg_ready.
- Word push: on wr_valid && wr_ready; the wr_last bit is stored alongside the word.
  - A push with wr_last=1 increments the complete-packet counter (width clog2(DEPTH+1)).
- Descriptors and payload are independent streams, matched in order: the Nth descriptor belongs to the Nth wr_last-terminated packet.
- Packets longer than DEPTH words are unsupported: wr_ready stays low and the stream stalls.
- Transfer rule: a flit transfers on a clk edge where net.enable && net.ack. Otherwise the flit is held unchanged.
- FSM states:
  - IDLE: enable=0.
    - Launch condition: descriptor FIFO non-empty AND complete-packet counter > 0.
    - Legal dst (dst.x <= X_EDGE, dst.y <= Y_EDGE, and (dst.x,dst.y) != (X,Y)) -> HEAD.
    - Illegal dst -> DROP.
  - HEAD: enable=1; flit_type=HEADER; payload = flit_hdr_t with dst_addr=descriptor dst, src_addr={X,Y}, all other bits 0.
    - On transfer: pop descriptor -> STREAM.
  - STREAM: enable=1; payload = FIFO head; flit_type=TAIL if the head's last bit is set, else BODY.
    - On transfer: pop word.
    - If the popped word was last: decrement the complete-packet counter, increment pkt_cnt -> IDLE.
  - DROP: enable=0; pops one word per cycle.
    - Popping the last word: pop the descriptor, decrement the counter, pulse err_dst in the cycle after, -> IDLE.
- Latency: launch condition seen in IDLE at edge N -> HEADER visible after edge N, in cycle N+1.
  - A one-word packet is HEADER then TAIL; minimum 2 enable cycles.
- Enable stays high continuously from HEADER through TAIL with ack stalls in between. It is low for at least 1 cycle between packets.
- net.flit is driven 0 whenever enable=0.
- Simultaneous push and pop on a full FIFO: the pop frees the entry but wr_ready is computed from registered occupancy, so a full FIFO still rejects that cycle's push.
- Simultaneous wr_last push and packet-completion pop: the counter net change is 0.

Test Plan:
- X=1,Y=1,edges=3; dst=(2,1), one word 0xA5 last=1, ack=1 -> HEADER(dst 2,1 src 1,1) then TAIL 0xA5 on consecutive cycles; enable high exactly 2 cycles; pkt_cnt=1.
- 3-word packet 0x1,0x2,0x3; ack held low 2 cycles during the HEADER and 1 cycle during BODY 0x2 -> enable never drops, each flit held stable while stalled, order HEADER,BODY 0x1,BODY 0x2,TAIL 0x3, 7 enable cycles.
- dst=(1,1) (self) with 2 words, followed by a legal packet to (0,1) -> no enable for the first, err_dst one pulse, second packet sent normally, pkt_cnt=1.
- DEPTH=8, ack=0: push 8 words with the last on word 8, then try a 9th -> wr_ready=0 after the 8th; once ack=1 the FIFO drains and wr_ready returns high.
- Words pushed before their descriptor: descriptor arrives 5 cycles later -> HEADER appears 1 cycle after the descriptor push, with no earlier enable.
- rst=0 asserted while in STREAM after the 2nd flit -> next cycle enable=0, busy=0, FIFOs empty; a fresh packet afterwards transmits correctly.

Source files
------------

// File: rtl/noc_injector_if.sv
// Shared NoC types and the node_port handshake interface.
//   noc_pkg   : coordinate, flit and header types.
//   node_port : flit + enable (upstream to downstream), ack (downstream to upstream).
//               A flit transfers on a clock edge where enable && ack.
package noc_pkg;

  localparam int unsigned CoordW   = 4;
  localparam int unsigned PayloadW = 32;

  typedef struct packed {
    logic [CoordW-1:0] x;
    logic [CoordW-1:0] y;
  } addr_t;

  // Zero is reserved so an idle (all-zero) flit never decodes as a real flit.
  typedef enum logic [1:0] {
    FlitNone   = 2'd0,
    FlitHeader = 2'd1,
    FlitBody   = 2'd2,
    FlitTail   = 2'd3
  } flit_type_e;

  typedef struct packed {
    flit_type_e            flit_type;
    logic [PayloadW-1:0]   payload;
  } flit_t;

  typedef struct packed {
    addr_t                        dst_addr;
    addr_t                        src_addr;
    logic [PayloadW-4*CoordW-1:0] rsvd;
  } flit_hdr_t;

endpackage

interface node_port;
  import noc_pkg::*;

  flit_t flit;
  logic  enable;
  logic  ack;

  modport up   (output flit, output enable, input ack);
  modport down (input flit, input enable, output ack);
endinterface

// File: rtl/noc_injector.sv
// Source-side network interface. Buffers descriptors and payload words from the local core,
// then serialises each complete packet as HEADER/BODY.../TAIL flits on a router input port.
// Ports:
//   clk, rst                      : clock, synchronous active-low reset
//   msg_valid/msg_ready/msg_dst   : descriptor stream (destination per packet)
//   wr_valid/wr_ready/wr_data/
//   wr_last                       : payload word stream, wr_last terminates a packet
//   net                           : node_port.up (drives flit/enable, samples ack)
//   busy                          : FSM not idle
//   err_dst                       : one-cycle pulse when a packet is dropped for a bad destination
//   pkt_cnt                       : packets fully sent (wrapping)
module noc_injector
  import noc_pkg::*;
#(
  parameter int unsigned X          = 1,
  parameter int unsigned Y          = 1,
  parameter int unsigned X_EDGE     = 1,
  parameter int unsigned Y_EDGE     = 1,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DESC_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                msg_valid,
  output logic                msg_ready,
  input  addr_t               msg_dst,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [PayloadW-1:0] wr_data,
  input  logic                wr_last,
  node_port.up                net,
  output logic                busy,
  output logic                err_dst,
  output logic [15:0]         pkt_cnt
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned DAW = $clog2(DESC_DEPTH);
  localparam int unsigned DCW = $clog2(DESC_DEPTH + 1);

  localparam logic [CoordW-1:0] XC     = CoordW'(X);
  localparam logic [CoordW-1:0] YC     = CoordW'(Y);
  localparam logic [CoordW-1:0] XEdgeC = CoordW'(X_EDGE);
  localparam logic [CoordW-1:0] YEdgeC = CoordW'(Y_EDGE);

  typedef enum logic [1:0] {StIdle, StHead, StStream, StDrop} state_e;

  state_e state_q, state_d;

  // Payload FIFO: each entry is {last, data}.
  logic [PayloadW:0]   mem_q [DEPTH];
  logic [AW-1:0]       wptr_q, rptr_q;
  logic [CW-1:0]       wcnt_q, wcnt_d;
  // Complete packets currently held in the payload FIFO.
  logic [CW-1:0]       done_q, done_d;

  // Descriptor FIFO.
  addr_t               dmem_q [DESC_DEPTH];
  logic [DAW-1:0]      dwptr_q, drptr_q;
  logic [DCW-1:0]      dcnt_q, dcnt_d;

  logic [15:0]         pkt_cnt_q;
  logic                err_q;

  logic                push, pop, dpush, dpop;
  logic                pkt_inc, drop_done;
  logic                head_last;
  logic [PayloadW-1:0] head_data;
  addr_t               dhead;
  logic                dst_legal;
  flit_hdr_t           hdr;
  flit_t               flit_o;
  logic                enable_o;

  assign wr_ready  = (wcnt_q != CW'(DEPTH));
  assign msg_ready = (dcnt_q != DCW'(DESC_DEPTH));
  assign push      = wr_valid && wr_ready;
  assign dpush     = msg_valid && msg_ready;

  assign head_last = mem_q[rptr_q][PayloadW];
  assign head_data = mem_q[rptr_q][PayloadW-1:0];
  assign dhead     = dmem_q[drptr_q];

  assign dst_legal = (dhead.x <= XEdgeC) && (dhead.y <= YEdgeC) &&
                     !((dhead.x == XC) && (dhead.y == YC));

  always_comb begin
    hdr          = '0;
    hdr.dst_addr = dhead;
    hdr.src_addr = '{x: XC, y: YC};
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    enable_o  = 1'b0;
    flit_o    = '0;
    pop       = 1'b0;
    dpop      = 1'b0;
    pkt_inc   = 1'b0;
    drop_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if ((dcnt_q != '0) && (done_q != '0)) begin
          state_d = dst_legal ? StHead : StDrop;
        end
      end
      StHead: begin
        enable_o         = 1'b1;
        flit_o.flit_type = FlitHeader;
        flit_o.payload   = hdr;
        if (net.ack) begin
          dpop    = 1'b1;
          state_d = StStream;
        end
      end
      StStream: begin
        enable_o         = 1'b1;
        flit_o.flit_type = head_last ? FlitTail : FlitBody;
        flit_o.payload   = head_data;
        if (net.ack) begin
          pop = 1'b1;
          if (head_last) begin
            pkt_inc = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StDrop: begin
        // done_q > 0 at launch guarantees the terminating word is already buffered.
        pop = 1'b1;
        if (head_last) begin
          dpop      = 1'b1;
          drop_done = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign net.enable = enable_o;
  assign net.flit   = flit_o;

  // Occupancy and complete-packet bookkeeping.
  always_comb begin
    wcnt_d = wcnt_q;
    if (push && !pop) begin
      wcnt_d = wcnt_q + CW'(1);
    end else if (!push && pop) begin
      wcnt_d = wcnt_q - CW'(1);
    end

    done_d = done_q;
    if ((push && wr_last) && !(pop && head_last)) begin
      done_d = done_q + CW'(1);
    end else if (!(push && wr_last) && (pop && head_last)) begin
      done_d = done_q - CW'(1);
    end

    dcnt_d = dcnt_q;
    if (dpush && !dpop) begin
      dcnt_d = dcnt_q + DCW'(1);
    end else if (!dpush && dpop) begin
      dcnt_d = dcnt_q - DCW'(1);
    end
  end

  // Storage arrays need no reset; pointers and counts define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= {wr_last, wr_data};
    end
    if (dpush) begin
      dmem_q[dwptr_q] <= msg_dst;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      wptr_q    <= '0;
      rptr_q    <= '0;
      wcnt_q    <= '0;
      done_q    <= '0;
      dwptr_q   <= '0;
      drptr_q   <= '0;
      dcnt_q    <= '0;
      pkt_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      done_q  <= done_d;
      dcnt_q  <= dcnt_d;
      err_q   <= drop_done;
      if (push) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + AW'(1);
      end
      if (dpush) begin
        dwptr_q <= dwptr_q + DAW'(1);
      end
      if (dpop) begin
        drptr_q <= drptr_q + DAW'(1);
      end
      if (pkt_inc) begin
        pkt_cnt_q <= pkt_cnt_q + 16'd1;
      end
    end
  end

  assign busy    = (state_q != StIdle);
  assign err_dst = err_q;
  assign pkt_cnt = pkt_cnt_q;

endmodule
